// File: rtl/quadrature_decoder.sv
// -----------------------------------------------------------------------------
// quadrature_decoder
//   Turns a bouncy, asynchronous 2-phase quadrature encoder (A/B) into a
//   wrapping position count. Each raw input is synchronized, A and B are
//   debounced independently, and a small INIT/RUN FSM primes the previous-state
//   register before any step is decoded. Steps are counted in x4 (every legal
//   Gray transition) or x1 (only the 10<->00 transition) mode.
//
// Ports
//   CLOCK_50  in   1   system clock, the only clock
//   KEY       in   4   [0] async active-low reset, [1] active-low error clear
//   SW        in   18  [0] run, [1] invert direction, [2] mode (1=x4, 0=x1)
//   GPIO      in   36  [0] phase A, [1] phase B (asynchronous, bouncy)
//   LEDR      out  18  position count, zero-extended above CNT_W
//   LEDG      out  8   [0] last step up, [1] last step down, [2] sticky error,
//                      [3] primed, [7:4] zero
// -----------------------------------------------------------------------------
module quadrature_decoder #(
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYCLES  = 500,
   parameter int CNT_W       = 18
) (
   input  logic        CLOCK_50,
   input  logic [3:0]  KEY,
   input  logic [17:0] SW,
   input  logic [35:0] GPIO,
   output logic [17:0] LEDR,
   output logic [7:0]  LEDG
);

   localparam int             DW      = $clog2(DEB_CYCLES + 1);
   localparam logic [DW-1:0]  DEB_MAX = DW'(DEB_CYCLES - 1);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   logic                   rst_n;
   logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q, sync_k_q;
   logic                   sync_a_s, sync_b_s, sync_k_s;
   logic [1:0]             sync_ab_s, sync_ab_nxt_s;
   logic                   stab_a_q, stab_a_d, stab_b_q, stab_b_d;
   logic [DW-1:0]          cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
   logic [DW-1:0]          init_cnt_q, init_cnt_d;
   logic [DW:0]            deb_a_s, deb_b_s;
   state_t                 state_q, state_d;
   logic [1:0]             prev_q, prev_d, cur_s;
   logic [CNT_W-1:0]       pos_q, pos_d;
   logic [1:0]             dir_q, dir_d;
   logic                   err_q, err_d, primed_q, primed_d;
   logic                   fwd_s, bwd_s, illegal_s, x1_edge_s, up_s;
   logic                   unused_s;

   assign rst_n    = KEY[0];
   assign unused_s = ^{KEY[3:2], SW[17:3], GPIO[35:2]};

   // One debounce step: returns {next stable, next counter}.
   function automatic logic [DW:0] deb_step(input logic sync_v, input logic stab_v,
                                            input logic [DW-1:0] cnt_v);
      logic [DW:0] r;
      if (sync_v != stab_v) begin
         if (cnt_v == DEB_MAX) begin
            r = {sync_v, {DW{1'b0}}};
         end else begin
            r = {stab_v, cnt_v + DW'(1)};
         end
      end else begin
         r = {stab_v, {DW{1'b0}}};
      end
      return r;
   endfunction

   assign sync_a_s      = sync_a_q[SYNC_STAGES-1];
   assign sync_b_s      = sync_b_q[SYNC_STAGES-1];
   assign sync_k_s      = sync_k_q[SYNC_STAGES-1];
   assign sync_ab_s     = {sync_a_s, sync_b_s};
   // Value the last synchronizer stage takes on the next edge.
   assign sync_ab_nxt_s = {sync_a_q[SYNC_STAGES-2], sync_b_q[SYNC_STAGES-2]};
   assign deb_a_s       = deb_step(sync_a_s, stab_a_q, cnt_a_q);
   assign deb_b_s       = deb_step(sync_b_s, stab_b_q, cnt_b_q);

   // Step classification of the debounced pair against the previous pair.
   assign cur_s     = {stab_a_q, stab_b_q};
   assign fwd_s     = (prev_q == 2'b00 && cur_s == 2'b01) || (prev_q == 2'b01 && cur_s == 2'b11) ||
                      (prev_q == 2'b11 && cur_s == 2'b10) || (prev_q == 2'b10 && cur_s == 2'b00);
   assign bwd_s     = (prev_q == 2'b01 && cur_s == 2'b00) || (prev_q == 2'b11 && cur_s == 2'b01) ||
                      (prev_q == 2'b10 && cur_s == 2'b11) || (prev_q == 2'b00 && cur_s == 2'b10);
   assign illegal_s = ((prev_q ^ cur_s) == 2'b11);
   assign x1_edge_s = (prev_q == 2'b10 && cur_s == 2'b00) || (prev_q == 2'b00 && cur_s == 2'b10);
   assign up_s      = fwd_s ^ SW[1];

   // Input synchronizer chains for A, B and the error-clear key.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         sync_a_q <= '0;
         sync_b_q <= '0;
         sync_k_q <= '0;
      end else begin
         sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], GPIO[0]};
         sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], GPIO[1]};
         sync_k_q <= {sync_k_q[SYNC_STAGES-2:0], KEY[1]};
      end
   end

   // Next-state logic: debounce, INIT/RUN FSM, step decode and counting.
   always_comb begin
      {stab_a_d, cnt_a_d} = deb_a_s;
      {stab_b_d, cnt_b_d} = deb_b_s;
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      prev_d     = prev_q;
      pos_d      = pos_q;
      dir_d      = dir_q;
      primed_d   = primed_q;
      if (!sync_k_s) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
      case (state_q)
         ST_INIT: begin
            // Restart the quiet window on the edge where the synced pair changes.
            if (sync_ab_nxt_s != sync_ab_s) begin
               init_cnt_d = '0;
            end else if (init_cnt_q == DEB_MAX) begin
               state_d    = ST_RUN;
               init_cnt_d = '0;
               prev_d     = sync_ab_s;
               stab_a_d   = sync_a_s;
               stab_b_d   = sync_b_s;
               cnt_a_d    = '0;
               cnt_b_d    = '0;
               primed_d   = 1'b1;
            end else begin
               init_cnt_d = init_cnt_q + DW'(1);
            end
         end
         ST_RUN: begin
            prev_d = cur_s;
            // Illegal wins over error clear; otherwise count qualified steps.
            if (illegal_s) begin
               err_d = 1'b1;
            end else if ((fwd_s || bwd_s) && SW[0] && (SW[2] || x1_edge_s)) begin
               if (up_s) begin
                  pos_d = pos_q + CNT_W'(1);
                  dir_d = 2'b01;
               end else begin
                  pos_d = pos_q - CNT_W'(1);
                  dir_d = 2'b10;
               end
            end else begin
               pos_d = pos_q;
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // State registers.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         stab_a_q   <= 1'b0;
         stab_b_q   <= 1'b0;
         cnt_a_q    <= '0;
         cnt_b_q    <= '0;
         init_cnt_q <= '0;
         state_q    <= ST_INIT;
         prev_q     <= 2'b00;
         pos_q      <= '0;
         dir_q      <= 2'b00;
         err_q      <= 1'b0;
         primed_q   <= 1'b0;
      end else begin
         stab_a_q   <= stab_a_d;
         stab_b_q   <= stab_b_d;
         cnt_a_q    <= cnt_a_d;
         cnt_b_q    <= cnt_b_d;
         init_cnt_q <= init_cnt_d;
         state_q    <= state_d;
         prev_q     <= prev_d;
         pos_q      <= pos_d;
         dir_q      <= dir_d;
         err_q      <= err_d;
         primed_q   <= primed_d;
      end
   end

   assign LEDR = 18'(pos_q);
   assign LEDG = {4'b0000, primed_q, err_q, dir_q};

endmodule

// File: tb/tb_quadrature_decoder.sv
// -----------------------------------------------------------------------------
// tb_quadrature_decoder
//   Directed bench for quadrature_decoder with DEB_CYCLES=4, SYNC_STAGES=2.
//   Inputs are driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_quadrature_decoder;

   logic        clk;
   logic [3:0]  key;
   logic [17:0] sw;
   logic [35:0] gpio;
   logic [17:0] ledr;
   logic [7:0]  ledg;
   logic [1:0]  cur_ab;
   int          n_vec;
   int          n_err;

   quadrature_decoder #(
      .SYNC_STAGES (2),
      .DEB_CYCLES  (4),
      .CNT_W       (18)
   ) dut (
      .CLOCK_50 (clk),
      .KEY      (key),
      .SW       (sw),
      .GPIO     (gpio),
      .LEDR     (ledr),
      .LEDG     (ledg)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ab = {A,B}; A on GPIO[0], B on GPIO[1].
   task automatic set_ab(input logic [1:0] ab);
      gpio[0] = ab[1];
      gpio[1] = ab[0];
      cur_ab  = ab;
   endtask

   function automatic logic [1:0] fwd_of(input logic [1:0] ab);
      case (ab)
         2'b00:   return 2'b01;
         2'b01:   return 2'b11;
         2'b11:   return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [1:0] bwd_of(input logic [1:0] ab);
      case (ab)
         2'b00:   return 2'b10;
         2'b10:   return 2'b11;
         2'b11:   return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   task automatic step_fwd();
      set_ab(fwd_of(cur_ab));
      repeat (10) tick();
   endtask

   task automatic step_bwd();
      set_ab(bwd_of(cur_ab));
      repeat (10) tick();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      key   = 4'b1110;
      sw    = 18'd0;
      gpio  = 36'd0;
      cur_ab = 2'b00;

      // 1: reset with A/B=11, prime without counting
      set_ab(2'b11);
      repeat (3) tick();
      chk("rst_ledr", 32'(ledr), 32'h0);
      chk("rst_ledg", 32'(ledg), 32'h0);
      key[0] = 1'b1;
      repeat (5) tick();
      chk("init_not_yet", 32'(ledg), 32'h00);
      tick();
      chk("primed_ledg", 32'(ledg), 32'h08);
      chk("primed_ledr", 32'(ledr), 32'h0);
      repeat (4) tick();

      // 2: x4 forward, latency of first step, then 7 more steps
      sw = 18'b101;
      set_ab(fwd_of(cur_ab));
      repeat (6) tick();
      chk("lat_6_edges", 32'(ledr), 32'h0);
      tick();
      chk("lat_7_edges", 32'(ledr), 32'h1);
      repeat (3) tick();
      for (int i = 0; i < 7; i++) step_fwd();
      chk("x4_fwd8_ledr", 32'(ledr), 32'd8);
      chk("x4_fwd8_ledg", 32'(ledg), 32'h09);

      // 3: x1 mode, 8 forward (2 counted), then 4 reverse (1 counted)
      sw = 18'b001;
      for (int i = 0; i < 8; i++) step_fwd();
      chk("x1_fwd8_ledr", 32'(ledr), 32'd10);
      for (int i = 0; i < 4; i++) step_bwd();
      chk("x1_bwd4_ledr", 32'(ledr), 32'd9);
      chk("x1_bwd4_ledg", 32'(ledg), 32'h0A);

      // 4: reset, reprime, wrap down then up
      key[0] = 1'b0;
      tick();
      key[0] = 1'b1;
      repeat (8) tick();
      chk("reprime_ledr", 32'(ledr), 32'h0);
      chk("reprime_ledg", 32'(ledg), 32'h08);
      sw = 18'b101;
      step_bwd();
      chk("wrap_down_ledr", 32'(ledr), 32'h3FFFF);
      chk("wrap_down_ledg", 32'(ledg), 32'h0A);
      step_fwd();
      chk("wrap_up_ledr", 32'(ledr), 32'h0);
      chk("wrap_up_ledg", 32'(ledg), 32'h09);

      // 5: short glitch on A, simultaneous A/B change, error clear
      gpio[0] = ~gpio[0];
      repeat (3) tick();
      gpio[0] = ~gpio[0];
      repeat (10) tick();
      chk("glitch_ledr", 32'(ledr), 32'h0);
      chk("glitch_ledg", 32'(ledg), 32'h09);
      set_ab(~cur_ab);
      repeat (10) tick();
      chk("illegal_ledg", 32'(ledg), 32'h0D);
      chk("illegal_ledr", 32'(ledr), 32'h0);
      key[1] = 1'b0;
      repeat (4) tick();
      key[1] = 1'b1;
      tick();
      chk("err_clear_ledg", 32'(ledg), 32'h09);

      // 6: run off while stepping, then run on; async reset mid-hold
      sw = 18'b100;
      for (int i = 0; i < 3; i++) step_fwd();
      chk("run_off_ledr", 32'(ledr), 32'h0);
      chk("run_off_ledg", 32'(ledg), 32'h09);
      sw = 18'b101;
      step_fwd();
      chk("run_on_ledr", 32'(ledr), 32'h1);
      chk("run_on_ledg", 32'(ledg), 32'h09);
      set_ab(fwd_of(cur_ab));
      repeat (3) tick();
      key[0] = 1'b0;
      #1;
      chk("async_rst_ledr", 32'(ledr), 32'h0);
      chk("async_rst_ledg", 32'(ledg), 32'h0);
      tick();
      key[0] = 1'b1;
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
